// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache; the master modport is the fetch unit and memory arbiter.
interface icache_if;
  logic        inst_req;
  logic [31:0] pc_in;
  logic        inst_ready;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport slave (
    input  inst_req, pc_in, mem_ready, mem_data,
    output inst_ready, inst, mem_req, mem_addr
  );

  modport master (
    output inst_req, pc_in, mem_ready, mem_data,
    input  inst_ready, inst, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, 4-word lines, zero-latency hits, word-serial line fill.
// Optional macro ICACHE_HIT_UNDER_FILL_EN serves hits to other lines while a fill runs.
module icache #(
  parameter int ICACHE_INDEX_BIT = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic rdy_in,
  icache_if.slave bus
);
  localparam int LINES = 1 << ICACHE_INDEX_BIT;
  localparam int TAG_W = 28 - ICACHE_INDEX_BIT;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]                  state;
  logic [1:0]                  cnt;
  logic                        mem_req_q;
  logic [31:0]                 mem_addr_q;
  logic [LINES-1:0]            valid;
  logic [TAG_W-1:0]            tag_arr  [LINES];
  logic [31:0]                 data_arr [LINES*4];

  logic [1:0]                  off;
  logic [ICACHE_INDEX_BIT-1:0] idx;
  logic [ICACHE_INDEX_BIT-1:0] fill_idx;
  logic [TAG_W-1:0]            tag;
  logic                        hit;
  logic                        serve;
  logic                        miss_start;
  logic                        fill_wr;
  logic                        unused_pc_lsb;

  assign off           = bus.pc_in[3:2];
  assign idx           = bus.pc_in[4+ICACHE_INDEX_BIT-1:4];
  assign tag           = bus.pc_in[31:4+ICACHE_INDEX_BIT];
  assign unused_pc_lsb = ^bus.pc_in[1:0];
  // The line being filled is always the one mem_addr points into.
  assign fill_idx      = mem_addr_q[4+ICACHE_INDEX_BIT-1:4];

  assign hit = valid[idx] && (tag_arr[idx] == tag);

  always_comb begin
    serve = 1'b0;
    if (state == IDLE) begin
      serve = 1'b1;
    end else begin
`ifdef ICACHE_HIT_UNDER_FILL_EN
      serve = (idx != fill_idx);
`else
      serve = 1'b0;
`endif
    end
  end

  assign bus.inst_ready = rst_n_in && rdy_in && bus.inst_req && hit && serve;
  assign bus.inst       = data_arr[{idx, off}];
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

  assign miss_start = rdy_in && (state == IDLE) && bus.inst_req && !hit;
  assign fill_wr    = rdy_in && (state == FILL) && bus.mem_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid      <= '0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            state      <= FILL;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {tag, idx, 4'b0000};
            valid[idx] <= 1'b0;
            cnt        <= '0;
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            if (cnt == 2'd3) begin
              valid[fill_idx] <= 1'b1;
              mem_req_q       <= 1'b0;
              state           <= IDLE;
              cnt             <= '0;
            end else begin
              cnt        <= cnt + 2'd1;
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_in) begin
    if (miss_start) tag_arr[idx] <= tag;
    if (fill_wr)    data_arr[{fill_idx, cnt}] <= bus.mem_data;
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: memory word at address A is 0xD000_0000 | A.
module tb_icache;
  logic clk_in;
  logic rst_n_in;
  logic rdy_in;
  int unsigned n_vec;
  int unsigned n_err;

  icache_if bus();

  icache #(.ICACHE_INDEX_BIT(4)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .bus      (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Serve nw words of a line fill starting at base, one mem_ready pulse per word.
  task automatic fill(input logic [31:0] base, input int unsigned nw);
    logic [31:0] a;
    for (int unsigned w = 0; w < nw; w++) begin
      a = base + 32'(4 * w);
      chk("fill_mem_req", {31'd0, bus.mem_req}, 32'd1);
      chk("fill_mem_addr", bus.mem_addr, a);
      bus.mem_data  = 32'hD000_0000 | a;
      bus.mem_ready = 1'b1;
      @(negedge clk_in);
      bus.mem_ready = 1'b0;
    end
  endtask

  task automatic hit(input string name, input logic [31:0] pc, input logic [31:0] exp_inst);
    bus.inst_req = 1'b1;
    bus.pc_in    = pc;
    #1;
    chk({name, "_ready"}, {31'd0, bus.inst_ready}, 32'd1);
    chk({name, "_inst"}, bus.inst, exp_inst);
  endtask

  task automatic miss(input string name, input logic [31:0] pc);
    bus.inst_req = 1'b1;
    bus.pc_in    = pc;
    #1;
    chk({name, "_ready"}, {31'd0, bus.inst_ready}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n_in      = 1'b0;
    rdy_in        = 1'b1;
    bus.inst_req  = 1'b0;
    bus.pc_in     = 32'h0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = 32'h0;
    repeat (2) @(negedge clk_in);

    // Reset state
    bus.inst_req = 1'b1;
    #1;
    chk("rst_ready", {31'd0, bus.inst_ready}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);

    // Cold miss at 0x0, fill, then hit on first IDLE cycle
    @(negedge clk_in);
    rst_n_in = 1'b1;
    miss("cold0", 32'h0);
    @(negedge clk_in);
    fill(32'h0, 4);
    hit("hit0", 32'h0, 32'hD000_0000);
    chk("hit0_mem_req", {31'd0, bus.mem_req}, 32'd0);
    hit("hit8", 32'h8, 32'hD000_0008);
    @(negedge clk_in);
    chk("hit8_no_req", {31'd0, bus.mem_req}, 32'd0);
    hit("hitC", 32'hC, 32'hD000_000C);

    // Load line 0x10 (index 1)
    miss("miss10", 32'h10);
    @(negedge clk_in);
    fill(32'h10, 4);
    hit("hit14", 32'h14, 32'hD000_0014);

    // Conflict at index 0; probe other lines during the fill
    miss("miss100", 32'h100);
    @(negedge clk_in);
    bus.pc_in = 32'h10;
    #1;
`ifdef ICACHE_HIT_UNDER_FILL_EN
    chk("huf_other_ready", {31'd0, bus.inst_ready}, 32'd1);
    chk("huf_other_inst", bus.inst, 32'hD000_0010);
`else
    chk("fill_other_ready", {31'd0, bus.inst_ready}, 32'd0);
`endif
    bus.pc_in = 32'h104;
    #1;
    chk("fill_same_ready", {31'd0, bus.inst_ready}, 32'd0);
    fill(32'h100, 4);
    hit("hit100", 32'h100, 32'hD000_0100);
    hit("hit108", 32'h108, 32'hD000_0108);
    miss("evict0", 32'h0);

    // Fill of 0x0 survives pc change and request drop
    @(negedge clk_in);
    bus.inst_req = 1'b0;
    bus.pc_in    = 32'h40;
    fill(32'h0, 4);
    chk("drop_done_req", {31'd0, bus.mem_req}, 32'd0);
    hit("after_drop0", 32'h4, 32'hD000_0004);
    miss("miss40", 32'h40);
    @(negedge clk_in);
    fill(32'h40, 4);
    hit("hit4C", 32'h4C, 32'hD000_004C);

    // rdy_in low freezes everything
    hit("pre_rdy", 32'h8, 32'hD000_0008);
    rdy_in = 1'b0;
    #1;
    chk("rdy_lo_hit_ready", {31'd0, bus.inst_ready}, 32'd0);
    bus.pc_in = 32'h500;
    @(negedge clk_in);
    chk("rdy_lo_no_fill", {31'd0, bus.mem_req}, 32'd0);
    rdy_in = 1'b1;
    miss("miss500", 32'h500);
    @(negedge clk_in);
    rdy_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rdy_lo_hold_req", {31'd0, bus.mem_req}, 32'd1);
    chk("rdy_lo_hold_addr", bus.mem_addr, 32'h500);
    rdy_in = 1'b1;
    fill(32'h500, 4);
    hit("hit508", 32'h508, 32'hD000_0508);

    // Reset after two words of a fill discards the line
    miss("miss300", 32'h300);
    @(negedge clk_in);
    fill(32'h300, 2);
    rst_n_in = 1'b0;
    #1;
    chk("midfill_rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("midfill_rst_addr", bus.mem_addr, 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    miss("post_rst_10", 32'h10);
    miss("post_rst_300", 32'h300);
    @(negedge clk_in);
    fill(32'h300, 4);
    hit("hit304", 32'h304, 32'hD000_0304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter ICACHE_INDEX_BIT, default 4, meaning log2 of line count (16 direct-mapped lines, 4 words / 16 bytes per line).
REQ-002 clk_in  input  1  clock; all state updates on rising edge.
REQ-003 rst_n_in  input  1  asynchronous, active-low reset.
REQ-004 rdy_in  input  1  ready; low freezes all state.
REQ-005 inst_req  input  1  fetch request from instruction unit, valid this cycle.
REQ-006 pc_in  input  32  fetch address; bits [1:0] ignored.
REQ-007 inst_ready  output  1  combinational; inst valid for pc_in this cycle.
REQ-008 inst  output  32  instruction word for pc_in.
REQ-009 mem_req  output  1  registered; word read request to memory arbiter.
REQ-010 mem_addr  output  32  registered; word-aligned read address, bits [1:0] = 0.
REQ-011 mem_ready  input  1  one-cycle pulse; mem_data holds the word for mem_addr.
REQ-012 mem_data  input  32  returned memory word.

Function
REQ-013 Address split: offset = pc_in[3:2], index = pc_in[4+ICACHE_INDEX_BIT-1:4], tag = pc_in[31:4+ICACHE_INDEX_BIT].
REQ-014 Hit = valid[index] and stored tag[index] equals tag.
REQ-015 States: IDLE, FILL.
REQ-016 IDLE: inst_ready = inst_req and hit and rdy_in, same cycle, zero latency; inst = data[index][offset].
REQ-017 IDLE, inst_req and miss and rdy_in: next cycle enter FILL, mem_req = 1, mem_addr = {tag, index, 4'b0000}, valid[index] = 0, tag[index] = tag, word counter = 0.
REQ-018 FILL: on mem_ready, write mem_data to data[fill index][counter]; counter increments; if counter < 3, mem_addr advances by 4 next cycle with mem_req held high.
REQ-019 FILL, mem_ready with counter = 3: next cycle valid[fill index] = 1, mem_req = 0, state = IDLE.
REQ-020 Miss penalty: the missed pc hits in the first IDLE cycle after fill completion.
REQ-021 FILL: inst_ready = 0 for every pc_in (unless ICACHE_HIT_UNDER_FILL_EN).
REQ-022 A started fill always completes; pc_in change or inst_req drop (branch clear, jalr stall) during FILL does not abort it.
REQ-023 mem_addr stays stable while mem_req high until mem_ready.
REQ-024 rdy_in low: state, counter, mem_req, mem_addr held; inst_ready = 0; arbiter guarantees no mem_ready while rdy_in low.
REQ-025 inst when inst_ready = 0 is don't-care.
REQ-026 inst_req with miss in the last FILL cycle is not accepted that cycle; it is re-evaluated in IDLE next cycle.

Reset
REQ-027 rst_n_in low, asynchronously: state = IDLE, all valid bits = 0, counter = 0, mem_req = 0, mem_addr = 0; inst_ready = 0.
REQ-028 Reset mid-FILL discards the partial line; line stays invalid.
REQ-029 Tag and data arrays need no reset.

Configuration
REQ-030 Macro ICACHE_HIT_UNDER_FILL_EN defined: in FILL, inst_ready = inst_req and hit and rdy_in when index differs from the fill index; same-index requests still get inst_ready = 0; misses are ignored until IDLE.
REQ-031 Macro undefined: REQ-021 applies unconditionally.

Verification
REQ-032 Reset, inst_req = 1, pc_in = 0x0 -> inst_ready = 0; next cycle mem_req = 1, mem_addr = 0x0; mem_addr steps 0x4, 0x8, 0xC after each mem_ready; first IDLE cycle inst_ready = 1, inst = word at 0x0.
REQ-033 After REQ-032 fill, pc_in = 0x8 -> inst_ready = 1 same cycle, inst = word at 0x8, mem_req stays 0.
REQ-034 Conflict: pc_in = 0x100 (index 0, tag 1) after line 0x0 loaded -> miss, fill from 0x100; afterwards pc_in = 0x0 misses again.
REQ-035 pc_in changed to 0x40 during fill of 0x0, inst_req dropped -> fill completes all 4 words; 0x0 hits later; 0x40 then misses.
REQ-036 rst_n_in pulsed low after second mem_ready of a fill -> mem_req = 0 immediately; pc_in = 0x0 misses again after reset release.
REQ-037 ICACHE_HIT_UNDER_FILL_EN defined, line 0x10 valid, fill of 0x100 running, pc_in = 0x10 -> inst_ready = 1; pc_in = 0x104 -> inst_ready = 0.
